lsu_bus_master: RTL and testbench
=================================

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 Parameter: STALL_CNT_W, 32, width of the stall-cycle counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  pipeline load/store request valid.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
REQ-009 req_unsigned  in  1  zero-extend load result.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  completion valid; held until resp_ready.
REQ-012 resp_ready  in  1  pipeline accepts completion.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  out  1  misaligned or illegal-size request.
REQ-015 Address  out  32  word-aligned bus address {req_addr[31:2],2'b00}.
REQ-016 MemRead / MemWrite  out  1 each  bus read / write request.
REQ-017 Write_data  out  32  lane-replicated store data.
REQ-018 Write_strb  out  4  byte enables.
REQ-019 Mem_Req_Ready  in  1  responder accepts request.
REQ-020 Read_data  in  32  returned word.
REQ-021 Read_data_Valid  in  1  read data valid.
REQ-022 Read_data_Ready  out  1  master accepts read data.
REQ-023 stall_cycles  out  STALL_CNT_W  cycles spent in REQ or RDATA since reset.

Function
REQ-024 The FSM SHALL have states IDLE, REQ, RDATA, DONE; req_ready = (state==IDLE) only.
REQ-025 IDLE: on accept, register all request fields; if misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 3), go to DONE with resp_err=1 and no bus activity; else go to REQ.
REQ-026 REQ: MemRead=!we, MemWrite=we, Address/Write_data/Write_strb stable; on Mem_Req_Ready at an edge, go to RDATA for loads and DONE for stores.
REQ-027 RDATA: Read_data_Ready=1; on Read_data_Valid at an edge, capture the extended result and go to DONE.
REQ-028 DONE: resp_valid=1 with stable resp_rdata/resp_err; on resp_ready at an edge, go to IDLE.
REQ-029 Minimum latency, accept to resp_valid: load 3 cycles, store 2 cycles, error 1 cycle, with zero-wait responder.
REQ-030 Write_strb: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; 0 outside REQ.
REQ-031 Write_data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-032 Load extract: Read_data>>(8*addr[1:0]), truncate to size, sign- or zero-extend per req_unsigned.
REQ-033 MemRead, MemWrite and Read_data_Ready SHALL be 0 outside their states; never both MemRead and MemWrite.
REQ-034 Read_data_Valid outside RDATA SHALL be ignored.
REQ-035 stall_cycles SHALL increment by 1 each cycle in REQ or RDATA, wrapping modulo 2^STALL_CNT_W.

Reset
REQ-036 When rst=0 at an edge: state IDLE; resp_valid, resp_err, MemRead, MemWrite, Read_data_Ready, Write_strb, stall_cycles, resp_rdata all 0; req_ready=1 the next cycle.
REQ-037 Reset mid-transaction SHALL abandon it with no response; bus request lines drop at that edge.

Structure
REQ-038 Shared package lsu_pkg SHALL hold the state enum, size encodings and the misalignment function.
REQ-039 Sub-module lsu_align (combinational strobe, write-lane and load-extract logic) SHALL be instantiated once.

Verification
REQ-040 Load word 0x8000_0010, Mem_Req_Ready after 2 cycles, Read_data=0xDEADBEEF -> resp_rdata 0xDEADBEEF, stall_cycles +3.
REQ-041 Load byte signed, addr 0x...3, Read_data 0x80112233 -> resp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-042 Store half 0xABCD to addr 0x...2 -> Write_strb 4'b1100, Write_data 0xABCDABCD, resp_valid 2 cycles after accept.
REQ-043 Load word addr 0x...1 -> resp_err=1 next cycle, MemRead never asserted, resp_rdata 0.
REQ-044 resp_ready held low 5 cycles in DONE -> outputs stable, req_ready 0 throughout.
REQ-045 rst=0 while in RDATA -> MemRead/Read_data_Ready 0 and state IDLE after that edge, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store bus master: FSM states, access-size
// encodings and the alignment check used at request accept.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  // Illegal size is reported through the same error path as misalignment.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return (offset != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes, lane-replicated store data and
// shifted/extended load data for one access.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wlane,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  always_comb begin
    case (offset)
      2'd0:    shifted = rdata;
      2'd1:    shifted = {8'h00, rdata[31:8]};
      2'd2:    shifted = {16'h0000, rdata[31:16]};
      default: shifted = {24'h000000, rdata[31:24]};
    endcase
  end

  always_comb begin
    strb     = 4'b0000;
    wlane    = wdata;
    load_ext = 32'h0;
    case (size)
      SZ_BYTE: begin
        strb     = 4'b0001 << offset;
        wlane    = {4{wdata[7:0]}};
        load_ext = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        strb     = 4'b0011 << {offset[1], 1'b0};
        wlane    = {2{wdata[15:0]}};
        load_ext = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        strb     = 4'b1111;
        wlane    = wdata;
        load_ext = shifted;
      end
      default: begin
        strb     = 4'b0000;
        wlane    = wdata;
        load_ext = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store master: accepts one pipeline request,
// runs it on the memory bus and holds the completion until consumed.
//   state    | meaning
//   ST_IDLE  | ready for a new request
//   ST_REQ   | bus request asserted, waiting for Mem_Req_Ready
//   ST_RDATA | load issued, waiting for Read_data_Valid
//   ST_DONE  | completion presented, waiting for resp_ready
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [31:0]            Address,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic [31:0]            Write_data,
  output logic [3:0]             Write_strb,
  input  logic                   Mem_Req_Ready,
  input  logic [31:0]            Read_data,
  input  logic                   Read_data_Valid,
  output logic                   Read_data_Ready,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  size_e                  size_q, size_d;
  logic                   uns_q, uns_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic        acc_mis;
  logic [3:0]  strb;
  logic [31:0] load_ext;

  assign acc_mis = is_misaligned(size_e'(req_size), req_addr[1:0]);

  lsu_align u_align (
    .size     (size_q),
    .offset   (addr_q[1:0]),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .rdata    (Read_data),
    .strb     (strb),
    .wlane    (Write_data),
    .load_ext (load_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = acc_mis ? ST_DONE : ST_REQ;
      ST_REQ:   if (Mem_Req_Ready) state_d = we_q ? ST_DONE : ST_RDATA;
      ST_RDATA: if (Read_data_Valid) state_d = ST_DONE;
      ST_DONE:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_d = stall_q;
    if (state_q == ST_IDLE && req_valid) begin
      we_d    = req_we;
      addr_d  = req_addr;
      size_d  = size_e'(req_size);
      uns_d   = req_unsigned;
      wdata_d = req_wdata;
      rdata_d = 32'h0;
      err_d   = acc_mis;
    end
    if (state_q == ST_RDATA && Read_data_Valid) rdata_d = load_ext;
    if (state_q == ST_REQ || state_q == ST_RDATA) stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_comb begin
    req_ready       = (state_q == ST_IDLE);
    MemRead         = (state_q == ST_REQ) && !we_q;
    MemWrite        = (state_q == ST_REQ) && we_q;
    Read_data_Ready = (state_q == ST_RDATA);
    resp_valid      = (state_q == ST_DONE);
    Write_strb      = (state_q == ST_REQ) ? strb : 4'b0000;
  end

  assign Address      = {addr_q[31:2], 2'b00};
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: completions are checked against a
// scoreboard queue filled when each request is issued.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
  logic [3:0]  Write_strb;
  logic [31:0] stall_cycles;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] stall_exp = 32'h0;

  always #5 clk = ~clk;

  lsu_bus_master #(.STALL_CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .Address         (Address),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .stall_cycles    (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
    int        off;
    logic [7:0]  b;
    logic [15:0] h;
    off = int'(a[1:0]);
    b = rd[off*8 +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd);
    chk("req_ready_before", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0;
  endtask

  task automatic wait_resp(input string tag, input int hold);
    int   w;
    exp_t e;
    w = 0;
    while (!resp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_latency"}, w, 0);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_nonempty"}, 32'h0, 32'h1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
        chk({tag, "_stall"}, stall_cycles, stall_exp);
        chk({tag, "_busidle"}, {30'h0, MemRead, MemWrite}, 32'h0);
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          chk({tag, "_hold_valid"}, {31'h0, resp_valid}, 32'h1);
          chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
          chk({tag, "_hold_err"}, {31'h0, resp_err}, {31'h0, e.err});
          chk({tag, "_hold_req_ready"}, {31'h0, req_ready}, 32'h0);
        end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, "_back_idle"}, {30'h0, req_ready, resp_valid}, 32'h2);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] rd, input int wait_n, input int hold);
    exp_t e;
    e.rdata = ld_model(rd, a, sz, u);
    e.err   = 1'b0;
    sb.push_back(e);
    Mem_Req_Ready = 1'b0;
    issue(1'b0, a, sz, u, 32'h0);
    chk({tag, "_memread"}, {30'h0, MemRead, MemWrite}, 32'h2);
    chk({tag, "_addr"}, Address, {a[31:2], 2'b00});
    chk({tag, "_rdready_req"}, {31'h0, Read_data_Ready}, 32'h0);
    for (int i = 0; i < wait_n; i++) begin
      Read_data = ~rd; Read_data_Valid = 1'b1;
      @(negedge clk);
      chk({tag, "_still_req"}, {31'h0, MemRead}, 32'h1);
    end
    Read_data_Valid = 1'b0;
    Mem_Req_Ready = 1'b1;
    @(negedge clk);
    Mem_Req_Ready = 1'b0;
    chk({tag, "_rdata_phase"}, {30'h0, Read_data_Ready, MemRead}, 32'h2);
    Read_data = rd; Read_data_Valid = 1'b1;
    @(negedge clk);
    Read_data_Valid = 1'b0; Read_data = 32'h0;
    stall_exp = stall_exp + 32'(wait_n + 2);
    wait_resp(tag, hold);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd);
    exp_t e;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    sb.push_back(e);
    Mem_Req_Ready = 1'b1;
    issue(1'b1, a, sz, 1'b0, wd);
    chk({tag, "_memwrite"}, {30'h0, MemRead, MemWrite}, 32'h1);
    chk({tag, "_strb"}, {28'h0, Write_strb}, {28'h0, exp_strb});
    chk({tag, "_wdata"}, Write_data, exp_wd);
    chk({tag, "_addr"}, Address, {a[31:2], 2'b00});
    chk({tag, "_not_yet_valid"}, {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    Mem_Req_Ready = 1'b0;
    stall_exp = stall_exp + 32'd1;
    chk({tag, "_strb_off"}, {28'h0, Write_strb}, 32'h0);
    wait_resp(tag, 0);
  endtask

  task automatic do_err(input string tag, input logic [31:0] a, input logic [1:0] sz);
    exp_t e;
    e.rdata = 32'h0;
    e.err   = 1'b1;
    sb.push_back(e);
    Mem_Req_Ready = 1'b1;
    issue(1'b0, a, sz, 1'b0, 32'h0);
    chk({tag, "_no_bus"}, {27'h0, Write_strb, MemRead}, 32'h0);
    wait_resp(tag, 0);
    Mem_Req_Ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    Mem_Req_Ready = 1'b0; Read_data = 32'h0; Read_data_Valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_ctrl", {27'h0, resp_valid, resp_err, MemRead, MemWrite, Read_data_Ready}, 32'h0);
    chk("rst_strb", {28'h0, Write_strb}, 32'h0);
    chk("rst_stall", stall_cycles, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    do_load("ld_word", 32'h8000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 1, 0);
    do_load("ld_byte_s", 32'h8000_0013, 2'd0, 1'b0, 32'h8011_2233, 0, 0);
    do_load("ld_byte_u", 32'h8000_0013, 2'd0, 1'b1, 32'h8011_2233, 0, 0);
    do_load("ld_half_s", 32'h0000_0102, 2'd1, 1'b0, 32'hF00D_1234, 2, 0);
    do_load("ld_half_u", 32'h0000_0100, 2'd1, 1'b1, 32'h1234_9ABC, 0, 0);
    do_load("ld_byte_1", 32'h0000_0041, 2'd0, 1'b0, 32'h0000_7F00, 0, 0);
    do_store("st_half", 32'h1000_0002, 2'd1, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store("st_byte", 32'h1000_0001, 2'd0, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A);
    do_store("st_word", 32'h1000_0008, 2'd2, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    do_err("err_word", 32'h2000_0001, 2'd2);
    do_err("err_half", 32'h2000_0003, 2'd1);
    do_err("err_size", 32'h2000_0000, 2'd3);
    do_load("ld_hold", 32'h0000_0200, 2'd2, 1'b0, 32'h1357_9BDF, 0, 5);

    // Reset during the read-data phase: the load must vanish without a response.
    Mem_Req_Ready = 1'b0;
    issue(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0);
    Mem_Req_Ready = 1'b1;
    @(negedge clk);
    Mem_Req_Ready = 1'b0;
    chk("rstmid_in_rdata", {31'h0, Read_data_Ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stall_exp = 32'h0;
    chk("rstmid_bus", {29'h0, MemRead, MemWrite, Read_data_Ready}, 32'h0);
    chk("rstmid_idle", {30'h0, req_ready, resp_valid}, 32'h2);
    chk("rstmid_stall", stall_cycles, 32'h0);
    Read_data_Valid = 1'b1; Read_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    Read_data_Valid = 1'b0;
    chk("rstmid_no_resp", {30'h0, resp_valid, req_ready}, 32'h1);
    do_load("ld_after_rst", 32'h0000_0030, 2'd0, 1'b1, 32'h00C3_0000, 0, 0);

    chk("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
